// File: rtl/vernam_pkg.sv
// Shared types and helpers for the streaming Vernam cipher.
package vernam_pkg;

    localparam int DATA_W_DEF    = 8;
    localparam int KEY_DEPTH_DEF = 16;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Advance through the active key, wrapping after the last of len words.
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned len);
        return (idx == len - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/vernam_key_ram.sv
// Key storage: one synchronous write port, asynchronous read of the current key word.
module vernam_key_ram #(
    parameter  int DATA_W    = 8,
    parameter  int KEY_DEPTH = 16,
    localparam int AW        = $clog2(KEY_DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [KEY_DEPTH];

    // Addresses beyond the key depth are silently dropped.
    always_ff @(posedge clk) begin
        if (we && (32'(waddr) < KEY_DEPTH))
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/vernam_stream_cipher.sv
// Streaming XOR cipher: cycles a loaded key over accepted words, one registered output stage.
module vernam_stream_cipher
    import vernam_pkg::*;
#(
    parameter  int DATA_W    = DATA_W_DEF,
    parameter  int KEY_DEPTH = KEY_DEPTH_DEF,
    localparam int AW        = $clog2(KEY_DEPTH),
    localparam int LW        = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_we,
    input  logic [AW-1:0]     key_waddr,
    input  logic [DATA_W-1:0] key_wdata,
    input  logic [LW-1:0]     cfg_len,
    input  logic              start,
    input  logic              stop,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              busy,
    output logic              cfg_err,
    output logic [AW-1:0]     key_idx
);

    state_t            state;
    logic [LW-1:0]     len_q;
    logic [DATA_W-1:0] key_word;
    logic              len_ok;
    logic              accept;

    assign len_ok  = (cfg_len != '0) && (cfg_len <= LW'(KEY_DEPTH));
    // stop closes the input port on its own cycle so no word slips in while leaving RUN.
    assign s_ready = (state == RUN) && !stop && (!m_valid || m_ready);
    assign accept  = s_valid && s_ready;

    vernam_key_ram #(
        .DATA_W    (DATA_W),
        .KEY_DEPTH (KEY_DEPTH)
    ) u_key_ram (
        .clk   (clk),
        .we    (key_we && (state == LOAD)),
        .waddr (key_waddr),
        .wdata (key_wdata),
        .raddr (key_idx),
        .rdata (key_word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= LOAD;
            len_q   <= LW'(1);
            key_idx <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            busy    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            case (state)
                LOAD: begin
                    if (start && !stop) begin
                        if (len_ok) begin
                            state   <= RUN;
                            busy    <= 1'b1;
                            len_q   <= cfg_len;
                            key_idx <= '0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (key_we)
                        cfg_err <= 1'b1;
                    if (stop) begin
                        state <= LOAD;
                        busy  <= 1'b0;
                    end
                end
                default: state <= LOAD;
            endcase

            // Output register drains in either state so a pending word survives stop.
            if (accept) begin
                m_data  <= s_data ^ key_word;
                m_valid <= 1'b1;
                key_idx <= AW'(next_idx(32'(key_idx), 32'(len_q)));
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule
